tempsens_seq_ctrl: RTL and testbench

//  Conversion sequencer between the TL-UL tempsensor register adapter and the

---
 rtl/tempsens_seq_ctrl.sv | 112 +++++++++++
 tb/tb_tempsens_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tempsens_seq_ctrl.sv
// tempsens_seq_ctrl: sequences temperature-sensor conversions, averages 2^k DOUT samples, flags timeout and high-temp alert
module tempsens_seq_ctrl #(
  parameter int CountW     = 24,
  parameter int AvgMaxLog2 = 3,
  parameter int SyncStages = 2,
  parameter int RstCycles  = 4,
  parameter int ToW        = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              continuous_i,
  input  logic [3:0]        sel_conv_time_i,
  input  logic [1:0]        avg_log2_i,
  input  logic [ToW-1:0]    timeout_i,
  input  logic [CountW-1:0] thresh_hi_i,
  input  logic              alert_clr_i,
  output logic              sensor_rst_no,
  output logic [3:0]        sensor_sel_o,
  output logic              sensor_en_o,
  input  logic [CountW-1:0] sensor_dout_i,
  input  logic              sensor_done_i,
  output logic [CountW-1:0] result_o,
  output logic              result_valid_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic              alert_hi_o
);
  localparam int AccW = CountW + AvgMaxLog2;
  localparam int KW   = AvgMaxLog2 > 0 ? $clog2(AvgMaxLog2 + 1) : 1;
  localparam int CW   = AvgMaxLog2 + 1;
  localparam int RW   = $clog2(RstCycles + 1);
  typedef enum logic [2:0] {IDLE, RST, ARM, CONV, CAPT, PUB} state_t;
  state_t state, state_d;
  logic [SyncStages-1:0] sync;
  logic done_s, done_q, last, to_hit, pub_go;
  logic [RW-1:0] rst_cnt;
  logic [ToW-1:0] to_cnt;
  logic [AccW-1:0] acc, sum;
  logic [CW-1:0] smp_cnt;
  logic [KW-1:0] k, k_in;
  logic [CountW-1:0] res;
  assign done_s = sync[SyncStages-1];
  always_comb begin
    sum    = acc + AccW'(sensor_dout_i);
    res    = CountW'(sum >> k);
    last   = (smp_cnt + 1'b1) == (CW'(1) << k);
    to_hit = (timeout_i != '0) && (({1'b0, to_cnt} + 1'b1) >= {1'b0, timeout_i});
    k_in   = int'(avg_log2_i) > AvgMaxLog2 ? KW'(AvgMaxLog2) : KW'(avg_log2_i);
    pub_go = state == CAPT && last && !stop_i;
    state_d = state;
    case (state)
      IDLE:    state_d = start_i ? RST : IDLE;
      RST:     state_d = rst_cnt == RW'(RstCycles - 1) ? ARM : RST;
      ARM:     state_d = to_hit ? IDLE : !done_s ? CONV : ARM;
      CONV:    state_d = to_hit ? IDLE : (done_s && !done_q) ? CAPT : CONV;
      CAPT:    state_d = last ? PUB : RST;
      PUB:     state_d = continuous_i ? RST : IDLE;
      default: state_d = IDLE;
    endcase
    if (stop_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      sync           <= '0;
      done_q         <= 1'b0;
      rst_cnt        <= '0;
      to_cnt         <= '0;
      acc            <= '0;
      smp_cnt        <= '0;
      k              <= '0;
      sensor_sel_o   <= '0;
      sensor_rst_no  <= 1'b1;
      sensor_en_o    <= 1'b0;
      busy_o         <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      timeout_o      <= 1'b0;
      alert_hi_o     <= 1'b0;
    end else begin
      state          <= state_d;
      sync           <= {sync[SyncStages-2:0], sensor_done_i};
      done_q         <= done_s;
      sensor_en_o    <= state_d == ARM || state_d == CONV;
      sensor_rst_no  <= state_d != RST;
      busy_o         <= state_d != IDLE;
      rst_cnt        <= state == RST ? rst_cnt + 1'b1 : '0;
      to_cnt         <= (state == ARM || state == CONV) ? ((&to_cnt) ? to_cnt : to_cnt + 1'b1) : '0;
      result_valid_o <= pub_go;
      alert_hi_o     <= (state == PUB && !stop_i && result_o > thresh_hi_i) | (alert_hi_o & ~alert_clr_i);
      if (state == IDLE && start_i && !stop_i) begin
        sensor_sel_o <= sel_conv_time_i;
        k            <= k_in;
        acc          <= '0;
        smp_cnt      <= '0;
        timeout_o    <= 1'b0;
      end
      if (state == CAPT && !stop_i) begin
        acc     <= sum;
        smp_cnt <= smp_cnt + 1'b1;
      end
      if (pub_go) result_o <= res;
      if (state == PUB) begin
        acc     <= '0;
        smp_cnt <= '0;
      end
      if ((state == ARM || state == CONV) && to_hit && !stop_i) timeout_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tempsens_seq_ctrl.sv
// tb_tempsens_seq_ctrl: randomized self-checking bench with a behavioural sensor macro and averaging reference
module tb_tempsens_seq_ctrl;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic start_i = 0, stop_i = 0, continuous_i = 0, alert_clr_i = 0;
  logic [3:0] sel_conv_time_i = 0;
  logic [1:0] avg_log2_i = 0;
  logic [19:0] timeout_i = 0;
  logic [23:0] thresh_hi_i = 24'hFFFFFF;
  logic sensor_rst_no, sensor_en_o, sensor_done_i, result_valid_o, busy_o, timeout_o, alert_hi_o;
  logic [3:0] sensor_sel_o;
  logic [23:0] sensor_dout_i, result_o;
  int checks = 0, errors = 0;
  int delay = 20, sticky = 0, rises = 0, n_valid = 0;
  bit never = 0;
  logic [23:0] vals[$];
  always #5 clk = ~clk;
  tempsens_seq_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .sel_conv_time_i(sel_conv_time_i),
    .avg_log2_i(avg_log2_i), .timeout_i(timeout_i), .thresh_hi_i(thresh_hi_i),
    .alert_clr_i(alert_clr_i), .sensor_rst_no(sensor_rst_no),
    .sensor_sel_o(sensor_sel_o), .sensor_en_o(sensor_en_o),
    .sensor_dout_i(sensor_dout_i), .sensor_done_i(sensor_done_i),
    .result_o(result_o), .result_valid_o(result_valid_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .alert_hi_o(alert_hi_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask
  task automatic wait_valid(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (result_valid_o) ok = 1;
    end
    if (!ok) chk("valid_wait", 32'(result_valid_o), 32'd1);
  endtask
  task automatic wait_en();
    for (int i = 0; i < 200 && !sensor_en_o; i++) tick();
    chk("en_wait", 32'(sensor_en_o), 32'd1);
  endtask
  // sensor macro: DONE rises after `delay` enabled cycles, falls once en drops (optionally `sticky` cycles late)
  initial begin : sensor
    int en_cnt, hold;
    bit pend;
    en_cnt = 0; hold = 0; pend = 0;
    sensor_done_i = 1'b0;
    sensor_dout_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        sensor_done_i = 1'b0; en_cnt = 0; pend = 0;
      end else if (sensor_done_i) begin
        if (pend) begin
          if (hold == 0) begin sensor_done_i = 1'b0; pend = 0; en_cnt = 0; end
          else hold--;
        end else if (!sensor_en_o) begin
          if (sticky == 0) begin sensor_done_i = 1'b0; en_cnt = 0; end
          else begin pend = 1; hold = sticky - 1; end
        end
      end else if (sensor_en_o) begin
        en_cnt++;
        if (!never && en_cnt >= delay) begin
          sensor_done_i = 1'b1;
          rises++;
          sensor_dout_i = vals.size() != 0 ? vals.pop_front() : 24'($urandom);
        end
      end else en_cnt = 0;
    end
  end
  initial begin : monitor
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (result_valid_o) n_valid++;
      if (!rst_ni) run = 0;
      else if (!sensor_rst_no) run++;
      else if (run != 0) begin
        chk("rst_low_len", 32'(run), 32'd4);
        run = 0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] sum, exp3;
    logic [23:0] v[6];
    logic [3:0] sel_s;
    int k, n, v0, r0, cnt;
    tick(2);
    chk("rst_rst_no", 32'(sensor_rst_no), 32'd1);
    chk("rst_en", 32'(sensor_en_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(result_valid_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_flags", {30'd0, timeout_o, alert_hi_o}, 32'd0);
    chk("rst_sel", 32'(sensor_sel_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    delay = 50; avg_log2_i = 0; sel_conv_time_i = 4'h5;
    vals.push_back(24'h001234);
    pulse_start();
    sel_conv_time_i = 4'hA;
    wait_valid(400);
    chk("t1_result", 32'(result_o), 32'h1234);
    chk("t1_sel", 32'(sensor_sel_o), 32'h5);
    tick();
    chk("t1_busy_after_pub", 32'(busy_o), 32'd0);
    chk("t1_single_pulse", 32'(result_valid_o), 32'd0);
    delay = 7; avg_log2_i = 2; v0 = n_valid;
    vals.push_back(24'd100); vals.push_back(24'd101); vals.push_back(24'd102); vals.push_back(24'd105);
    pulse_start();
    wait_valid(1000);
    chk("t2_result", 32'(result_o), 32'd102);
    tick(20);
    chk("t2_pulses", 32'(n_valid - v0), 32'd1);
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(0, 3);
      n = 1 << k;
      sum = 0;
      for (int i = 0; i < n; i++) begin
        v[0] = 24'($urandom);
        vals.push_back(v[0]);
        sum += 32'(v[0]);
      end
      delay = $urandom_range(3, 40);
      avg_log2_i = 2'(k);
      sel_s = 4'($urandom);
      sel_conv_time_i = sel_s;
      pulse_start();
      sel_conv_time_i = ~sel_s;
      wait_valid(2000);
      chk("rand_result", 32'(result_o), sum >> k);
      chk("rand_sel", 32'(sensor_sel_o), 32'(sel_s));
      tick();
      chk("rand_idle", 32'(busy_o), 32'd0);
    end
    never = 1; timeout_i = 20'd200; avg_log2_i = 0; v0 = n_valid; cnt = 0;
    pulse_start();
    for (int i = 0; i < 1000 && !timeout_o; i++) begin
      tick();
      if (sensor_en_o) cnt++;
    end
    chk("t3_timeout", 32'(timeout_o), 32'd1);
    chk("t3_cycles", 32'(cnt), 32'd200);
    chk("t3_idle", 32'(busy_o), 32'd0);
    chk("t3_no_result", 32'(n_valid - v0), 32'd0);
    pulse_start();
    chk("t3_clear", 32'(timeout_o), 32'd0);
    wait_en();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("t3_stop_idle", 32'(busy_o), 32'd0);
    timeout_i = 0; never = 0;
    thresh_hi_i = 24'h1000; delay = 10;
    vals.push_back(24'h1001);
    pulse_start();
    wait_valid(500);
    chk("t4_result", 32'(result_o), 32'h1001);
    tick();
    chk("t4_alert_set", 32'(alert_hi_o), 32'd1);
    vals.push_back(24'h2000);
    pulse_start();
    wait_valid(500);
    alert_clr_i = 1'b1;
    tick();
    alert_clr_i = 1'b0;
    chk("t4_set_wins", 32'(alert_hi_o), 32'd1);
    alert_clr_i = 1'b1;
    tick();
    alert_clr_i = 1'b0;
    chk("t4_lone_clr", 32'(alert_hi_o), 32'd0);
    vals.push_back(24'h1000);
    pulse_start();
    wait_valid(500);
    tick();
    chk("t4_equal_no_alert", 32'(alert_hi_o), 32'd0);
    continuous_i = 1'b1; avg_log2_i = 1; delay = 8;
    for (int i = 0; i < 6; i++) begin
      v[i] = 24'($urandom);
      vals.push_back(v[i]);
    end
    sel_s = 4'h3;
    sel_conv_time_i = sel_s;
    pulse_start();
    exp3 = 0;
    for (int j = 0; j < 3; j++) begin
      wait_valid(1000);
      exp3 = (32'(v[2*j]) + 32'(v[2*j+1])) >> 1;
      chk("t5_result", 32'(result_o), exp3);
      if (j == 0) begin
        tick();
        sel_conv_time_i = 4'hC;
        avg_log2_i = 3;
        pulse_start();
        chk("t5_start_ignored", 32'(sensor_sel_o), 32'(sel_s));
      end
    end
    never = 1;
    wait_en();
    tick(5);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("t5_stop_busy", 32'(busy_o), 32'd0);
    chk("t5_stop_en", 32'(sensor_en_o), 32'd0);
    chk("t5_stop_rst_no", 32'(sensor_rst_no), 32'd1);
    chk("t5_keep_result", 32'(result_o), exp3);
    continuous_i = 1'b0; never = 0;
    tick(5);
    sticky = 20; delay = 10; avg_log2_i = 1;
    v[0] = 24'($urandom); v[1] = 24'($urandom);
    vals.push_back(v[0]); vals.push_back(v[1]);
    r0 = rises;
    pulse_start();
    wait_valid(1000);
    chk("t6_stale_done_result", 32'(result_o), (32'(v[0]) + 32'(v[1])) >> 1);
    chk("t6_rises", 32'(rises - r0), 32'd2);
    tick(30);
    sticky = 0; never = 1; avg_log2_i = 0;
    pulse_start();
    wait_en();
    tick(10);
    rst_ni = 1'b0;
    #1;
    chk("t6_arst_en", 32'(sensor_en_o), 32'd0);
    chk("t6_arst_rst_no", 32'(sensor_rst_no), 32'd1);
    chk("t6_arst_busy", 32'(busy_o), 32'd0);
    chk("t6_arst_result", 32'(result_o), 32'd0);
    chk("t6_arst_sel", 32'(sensor_sel_o), 32'd0);
    chk("t6_arst_flags", {29'd0, result_valid_o, timeout_o, alert_hi_o}, 32'd0);
    tick();
    rst_ni = 1'b1; never = 0;
    tick();
    vals.push_back(24'h00ABCD);
    pulse_start();
    wait_valid(500);
    chk("t6_after_reset", 32'(result_o), 32'h00ABCD);
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
